// File: rtl/tp_pkg.sv
// Shared types and defaults for the VGA test-pattern frame sequencer.
package tp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN
  } tp_seq_st_t;

  typedef enum logic [1:0] {
    PAT_BLACK,
    PAT_COLORBAR,
    PAT_GRAD,
    PAT_CHECKER
  } tp_pat_t;

  localparam int TP_NUM_PAT = 4;
  localparam int TP_HACT    = 640;
  localparam int TP_VACT    = 480;

  // A hold of zero frames would never advance, so it behaves as one frame.
  function automatic logic [7:0] eff_hold(input logic [7:0] hold);
    return (hold == 8'd0) ? 8'd1 : hold;
  endfunction

endpackage

// File: rtl/tp_coord_cnt.sv
// Sync edge detection, active-pixel column/row tracking and active-window
// geometry checking for the test-pattern sequencer.
module tp_coord_cnt
  import tp_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int HACT    = TP_HACT,
  parameter int VACT    = TP_VACT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               vsync,
  input  logic               dval,
  output logic               vs_rise,
  output logic               vs_fall,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               geo_err
);

  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(HACT - 1);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(VACT - 1);
  localparam logic [COORD_W:0]   HACT_W  = (COORD_W + 1)'(HACT);
  localparam logic [COORD_W:0]   VACT_W  = (COORD_W + 1)'(VACT);

  logic               vs_d;
  logic               dv_d;
  logic               dv_fall;
  logic [COORD_W:0]   pix_cnt;
  logic [COORD_W:0]   line_cnt;
  logic [COORD_W:0]   line_total;

  assign vs_rise = vsync & ~vs_d;
  assign vs_fall = ~vsync & vs_d;
  assign dv_fall = ~dval & dv_d;

  // A line ending on the very cycle vsync drops still belongs to this frame.
  assign line_total = line_cnt + {{COORD_W{1'b0}}, dv_fall};

  assign geo_err = en & ((dv_fall & (pix_cnt != HACT_W)) |
                         (vs_fall & (line_total != VACT_W)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      dv_d <= 1'b0;
    end else begin
      vs_d <= vsync;
      dv_d <= dval;
    end
  end

  // Separate error counters keep counting after col/row saturate.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      col      <= '0;
      row      <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (vs_rise) begin
      col      <= '0;
      row      <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (dv_fall) begin
        col      <= '0;
        row      <= (row < ROW_MAX) ? row + 1'b1 : row;
        pix_cnt  <= '0;
        line_cnt <= (line_cnt != '1) ? line_cnt + 1'b1 : line_cnt;
      end else if (dval) begin
        col     <= (col < COL_MAX) ? col + 1'b1 : col;
        pix_cnt <= (pix_cnt != '1) ? pix_cnt + 1'b1 : pix_cnt;
      end
      if (vs_fall) begin
        line_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tp_frame_sequencer.sv
// Frame-level controller for the VGA test-pattern generator: start/stop,
// frame-aligned pattern selection with optional auto-cycling, frame counting.
module tp_frame_sequencer
  import tp_pkg::*;
#(
  parameter int NUM_PAT = TP_NUM_PAT,
  parameter int PAT_W   = 2,
  parameter int FCNT_W  = 16,
  parameter int COORD_W = 11,
  parameter int HACT    = TP_HACT,
  parameter int VACT    = TP_VACT
) (
  input  logic               px_clk,
  input  logic               sys_rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [PAT_W-1:0]   pat_mode_i,
  input  logic [7:0]         hold_frames_i,
  input  logic               auto_cycle_i,
  input  logic               vsync_i,
  input  logic               dval_i,
  output logic               tp_en_o,
  output logic [PAT_W-1:0]   pat_sel_o,
  output logic               pat_update_o,
  output logic [COORD_W-1:0] col_o,
  output logic [COORD_W-1:0] row_o,
  output logic [FCNT_W-1:0]  frame_cnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timing_err_o
);

  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PAT - 1);

  tp_seq_st_t       state;
  logic [7:0]       hold_lat;
  logic [7:0]       hold_cnt;
  logic             auto_lat;
  logic             coord_en;
  logic             vs_rise;
  logic             vs_fall;
  logic             geo_err;
  logic             advance;
  logic [PAT_W-1:0] next_pat;

  assign coord_en = (state == ST_RUN) || (state == ST_DRAIN);
  assign next_pat = (pat_sel_o >= PAT_LAST) ? '0 : pat_sel_o + 1'b1;
  assign advance  = auto_lat &&
                    (({1'b0, hold_cnt} + 9'd1) >= {1'b0, eff_hold(hold_lat)});

  tp_coord_cnt #(
    .COORD_W (COORD_W),
    .HACT    (HACT),
    .VACT    (VACT)
  ) u_coord (
    .clk     (px_clk),
    .rst_n   (sys_rst_n),
    .en      (coord_en),
    .vsync   (vsync_i),
    .dval    (dval_i),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall),
    .col     (col_o),
    .row     (row_o),
    .geo_err (geo_err)
  );

  always_ff @(posedge px_clk) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      hold_lat     <= '0;
      hold_cnt     <= '0;
      auto_lat     <= 1'b0;
      tp_en_o      <= 1'b0;
      pat_sel_o    <= '0;
      pat_update_o <= 1'b0;
      frame_cnt_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      timing_err_o <= 1'b0;
    end else begin
      pat_update_o <= 1'b0;
      done_o       <= 1'b0;
      if (geo_err) begin
        timing_err_o <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            hold_lat     <= hold_frames_i;
            auto_lat     <= auto_cycle_i;
            pat_sel_o    <= pat_mode_i;
            frame_cnt_o  <= '0;
            hold_cnt     <= '0;
            timing_err_o <= 1'b0;
            tp_en_o      <= 1'b1;
            busy_o       <= 1'b1;
            state        <= ST_ARM;
          end
        end

        ST_ARM: begin
          if (stop_i) begin
            tp_en_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state   <= ST_IDLE;
          end else if (vs_rise) begin
            pat_update_o <= 1'b1;
            state        <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (vs_fall) begin
            frame_cnt_o <= frame_cnt_o + 1'b1;
            if (advance) begin
              pat_sel_o    <= next_pat;
              hold_cnt     <= '0;
              pat_update_o <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          // A stop in blanking (including the vs_fall cycle) ends at once.
          if (stop_i) begin
            if (!vsync_i) begin
              tp_en_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (vs_fall) begin
            frame_cnt_o <= frame_cnt_o + 1'b1;
            tp_en_o     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
